// File: rtl/id_stage_pkg.sv
// Shared decode definitions for the ID stage: RV32I opcodes, the bubble
// instruction and the instruction-format classification.
package id_stage_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

  // FMT_I covers OP-IMM, LOAD and JALR; FMT_X is anything not decoded here
  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X
  } fmt_e;

  function automatic fmt_e opc_fmt(input logic [6:0] opc);
    case (opc)
      OPC_OP:                          return FMT_R;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR:  return FMT_I;
      OPC_STORE:                       return FMT_S;
      OPC_BRANCH:                      return FMT_B;
      OPC_LUI, OPC_AUIPC:              return FMT_U;
      OPC_JAL:                         return FMT_J;
      default:                         return FMT_X;
    endcase
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// ID/EX pipeline-register bundle travelling from the decode stage to EX.
interface id_ex_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int REG_AW = 5
);
  logic [31:0]       ins_o;
  logic [ADDR_W-1:0] ins_addr_o;
  logic              valid_o;
  logic [XLEN-1:0]   reg1_rd_data_o;
  logic [XLEN-1:0]   reg2_rd_data_o;
  logic [XLEN-1:0]   imm_o;
  logic [REG_AW-1:0] reg_wr_addr_o;
  logic              reg_wr_en_o;

  modport master (
    output ins_o, ins_addr_o, valid_o, reg1_rd_data_o, reg2_rd_data_o,
           imm_o, reg_wr_addr_o, reg_wr_en_o
  );

  modport slave (
    input ins_o, ins_addr_o, valid_o, reg1_rd_data_o, reg2_rd_data_o,
          imm_o, reg_wr_addr_o, reg_wr_en_o
  );
endinterface

// File: rtl/id_stage_decode.sv
// Combinational RV32I field decoder: register addresses, operand-use flags,
// rd write enable and the sign-extended immediate.
module id_decode
  import id_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic [31:0]       ins,
  output logic [REG_AW-1:0] rs1,
  output logic [REG_AW-1:0] rs2,
  output logic [REG_AW-1:0] rd,
  output logic              use_rs1,
  output logic              use_rs2,
  output logic              wr_en,
  output logic [XLEN-1:0]   imm
);

  fmt_e               fmt;
  logic signed [31:0] imm32;

  assign rs1 = REG_AW'(ins[19:15]);
  assign rs2 = REG_AW'(ins[24:20]);
  assign rd  = REG_AW'(ins[11:7]);

  // Classify the opcode and build the format-specific immediate
  always_comb begin
    fmt     = opc_fmt(ins[6:0]);
    imm32   = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    wr_en   = 1'b0;
    case (fmt)
      FMT_R: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        wr_en   = 1'b1;
      end
      FMT_I: begin
        imm32   = {{20{ins[31]}}, ins[31:20]};
        use_rs1 = 1'b1;
        wr_en   = 1'b1;
      end
      FMT_S: begin
        imm32   = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      FMT_B: begin
        imm32   = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      FMT_U: begin
        imm32 = {ins[31:12], 12'b0};
        wr_en = 1'b1;
      end
      FMT_J: begin
        imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        wr_en = 1'b1;
      end
      default: ;
    endcase
    // writes to x0 are architecturally discarded, so never request them
    if (rd == '0) wr_en = 1'b0;
  end

  assign imm = XLEN'(imm32);

endmodule

// File: rtl/id_stage.sv
// Decode stage with EX/MEM operand forwarding, load-use hazard detection and
// the ID/EX pipeline register (hold, flush and bubble insertion).
module id_stage
  import id_stage_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter int          ADDR_W   = 32,
  parameter int          REG_AW   = 5,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF,
  parameter bit          FWD_EN   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold_flag_i,
  input  logic              flush_i,
  input  logic              ins_valid_i,
  input  logic [31:0]       ins_i,
  input  logic [ADDR_W-1:0] ins_addr_i,
  output logic [REG_AW-1:0] reg1_rd_addr_o,
  output logic [REG_AW-1:0] reg2_rd_addr_o,
  input  logic [XLEN-1:0]   reg1_rd_data_i,
  input  logic [XLEN-1:0]   reg2_rd_data_i,
  input  logic              ex_wr_en_i,
  input  logic [REG_AW-1:0] ex_wr_addr_i,
  input  logic [XLEN-1:0]   ex_wr_data_i,
  input  logic              ex_is_load_i,
  input  logic              mem_wr_en_i,
  input  logic [REG_AW-1:0] mem_wr_addr_i,
  input  logic [XLEN-1:0]   mem_wr_data_i,
  output logic              stall_req_o,
  id_ex_if.master           ex_bus
);

  logic [REG_AW-1:0] rs1, rs2, rd;
  logic              use_rs1, use_rs2, wr_en;
  logic [XLEN-1:0]   imm;
  logic [XLEN-1:0]   op1, op2;
  logic              load_bubble;

  id_decode #(.XLEN(XLEN), .REG_AW(REG_AW)) u_dec (
    .ins     (ins_i),
    .rs1     (rs1),
    .rs2     (rs2),
    .rd      (rd),
    .use_rs1 (use_rs1),
    .use_rs2 (use_rs2),
    .wr_en   (wr_en),
    .imm     (imm)
  );

  assign reg1_rd_addr_o = rs1;
  assign reg2_rd_addr_o = rs2;

  // A load in EX has no data yet, so it is excluded from EX forwarding and
  // instead triggers the stall; the retry then finds the value in MEM.
  function automatic logic [XLEN-1:0] resolve(
    input logic [REG_AW-1:0] src,
    input logic [XLEN-1:0]   rf_data
  );
    if (!FWD_EN)                                               return rf_data;
    if (src == '0)                                             return '0;
    if (ex_wr_en_i && ex_wr_addr_i == src && !ex_is_load_i)    return ex_wr_data_i;
    if (mem_wr_en_i && mem_wr_addr_i == src)                   return mem_wr_data_i;
    return rf_data;
  endfunction

  // Operand selection and load-use hazard compare
  always_comb begin
    op1 = resolve(rs1, reg1_rd_data_i);
    op2 = resolve(rs2, reg2_rd_data_i);
    stall_req_o = ins_valid_i && ex_wr_en_i && ex_is_load_i && (ex_wr_addr_i != '0)
                  && ((use_rs1 && rs1 == ex_wr_addr_i) || (use_rs2 && rs2 == ex_wr_addr_i));
    // flush overrides hold; stall and empty slots only bubble when not held
    load_bubble = flush_i || (!hold_flag_i && (stall_req_o || !ins_valid_i));
  end

  // ID/EX register: bubble, hold or capture the decoded instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || load_bubble) begin
      ex_bus.ins_o          <= NOP_INST;
      ex_bus.ins_addr_o     <= '0;
      ex_bus.valid_o        <= 1'b0;
      ex_bus.reg1_rd_data_o <= '0;
      ex_bus.reg2_rd_data_o <= '0;
      ex_bus.imm_o          <= '0;
      ex_bus.reg_wr_addr_o  <= '0;
      ex_bus.reg_wr_en_o    <= 1'b0;
    end else if (!hold_flag_i) begin
      ex_bus.ins_o          <= ins_i;
      ex_bus.ins_addr_o     <= ins_addr_i;
      ex_bus.valid_o        <= 1'b1;
      ex_bus.reg1_rd_data_o <= op1;
      ex_bus.reg2_rd_data_o <= op2;
      ex_bus.imm_o          <= imm;
      ex_bus.reg_wr_addr_o  <= rd;
      ex_bus.reg_wr_en_o    <= wr_en;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Testbench for id_stage: directed scenarios followed by randomized traffic,
// all checked against a behavioural decode/forward/register model.
module tb_id_stage;
  import id_stage_pkg::*;

  localparam int XLEN = 32, ADDR_W = 32, REG_AW = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold, flush, ins_valid;
  logic [31:0] ins, ins_addr;
  logic [4:0]  rd_addr1, rd_addr2, nf_rd_addr1, nf_rd_addr2;
  logic [31:0] rf1, rf2;
  logic        ex_wr_en, ex_is_load, mem_wr_en;
  logic [4:0]  ex_wr_addr, mem_wr_addr;
  logic [31:0] ex_wr_data, mem_wr_data;
  logic        stall, nf_stall;

  id_ex_if #(.XLEN(XLEN), .ADDR_W(ADDR_W), .REG_AW(REG_AW)) bus ();
  id_ex_if #(.XLEN(XLEN), .ADDR_W(ADDR_W), .REG_AW(REG_AW)) bus_nf ();

  always #5 clk = ~clk;

  id_stage #(.XLEN(XLEN), .ADDR_W(ADDR_W), .REG_AW(REG_AW), .FWD_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .hold_flag_i(hold), .flush_i(flush),
    .ins_valid_i(ins_valid), .ins_i(ins), .ins_addr_i(ins_addr),
    .reg1_rd_addr_o(rd_addr1), .reg2_rd_addr_o(rd_addr2),
    .reg1_rd_data_i(rf1), .reg2_rd_data_i(rf2),
    .ex_wr_en_i(ex_wr_en), .ex_wr_addr_i(ex_wr_addr), .ex_wr_data_i(ex_wr_data),
    .ex_is_load_i(ex_is_load), .mem_wr_en_i(mem_wr_en), .mem_wr_addr_i(mem_wr_addr),
    .mem_wr_data_i(mem_wr_data), .stall_req_o(stall), .ex_bus(bus.master)
  );

  id_stage #(.XLEN(XLEN), .ADDR_W(ADDR_W), .REG_AW(REG_AW), .FWD_EN(1'b0)) u_nf (
    .clk(clk), .rst_n(rst_n), .hold_flag_i(hold), .flush_i(flush),
    .ins_valid_i(ins_valid), .ins_i(ins), .ins_addr_i(ins_addr),
    .reg1_rd_addr_o(nf_rd_addr1), .reg2_rd_addr_o(nf_rd_addr2),
    .reg1_rd_data_i(rf1), .reg2_rd_data_i(rf2),
    .ex_wr_en_i(ex_wr_en), .ex_wr_addr_i(ex_wr_addr), .ex_wr_data_i(ex_wr_data),
    .ex_is_load_i(ex_is_load), .mem_wr_en_i(mem_wr_en), .mem_wr_addr_i(mem_wr_addr),
    .mem_wr_data_i(mem_wr_data), .stall_req_o(nf_stall), .ex_bus(bus_nf.master)
  );

  int n_cmp = 0;
  int n_err = 0;

  // expected ID/EX contents
  logic [31:0] e_ins, e_addr, e_r1, e_r2, e_imm, e_r2_nf;
  logic [4:0]  e_rd;
  logic        e_we, e_vld;

  typedef struct packed {
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2, we;
  } dec_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decode written from the ISA immediate definitions with shifts
  function automatic dec_t ref_dec(input logic [31:0] i);
    dec_t d;
    logic signed [31:0] s, sx20, sx25, sx31;
    s = i; sx20 = s >>> 20; sx25 = s >>> 25; sx31 = s >>> 31;
    d = '0;
    d.rs1 = i[19:15]; d.rs2 = i[24:20]; d.rd = i[11:7];
    case (i[6:0])
      7'h33: begin d.u1 = 1; d.u2 = 1; d.we = 1; end
      7'h13, 7'h03, 7'h67: begin d.imm = sx20; d.u1 = 1; d.we = 1; end
      7'h23: begin d.imm = (sx25 << 5) | 32'(i[11:7]); d.u1 = 1; d.u2 = 1; end
      7'h63: begin
        d.imm = (sx31 << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
        d.u1 = 1; d.u2 = 1;
      end
      7'h37, 7'h17: begin d.imm = i & 32'hFFFF_F000; d.we = 1; end
      7'h6F: begin
        d.imm = (sx31 << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
        d.we = 1;
      end
      default: ;
    endcase
    if (d.rd == 0) d.we = 0;
    return d;
  endfunction

  function automatic logic [31:0] ref_opnd(input logic [4:0] a, input logic [31:0] rf, input bit fwd);
    if (!fwd) return rf;
    if (a == 0) return 32'h0;
    if (ex_wr_en && ex_wr_addr == a && !ex_is_load) return ex_wr_data;
    if (mem_wr_en && mem_wr_addr == a) return mem_wr_data;
    return rf;
  endfunction

  task automatic exp_bubble();
    e_ins = 32'h0000_0013; e_addr = 0; e_r1 = 0; e_r2 = 0; e_imm = 0;
    e_rd = 0; e_we = 0; e_vld = 0; e_r2_nf = 0;
  endtask

  task automatic check_regs(input string pfx);
    chk({pfx, ".ins_o"},       bus.ins_o,          e_ins);
    chk({pfx, ".ins_addr_o"},  bus.ins_addr_o,     e_addr);
    chk({pfx, ".valid_o"},     32'(bus.valid_o),   32'(e_vld));
    chk({pfx, ".reg1_data"},   bus.reg1_rd_data_o, e_r1);
    chk({pfx, ".reg2_data"},   bus.reg2_rd_data_o, e_r2);
    chk({pfx, ".imm_o"},       bus.imm_o,          e_imm);
    chk({pfx, ".wr_addr"},     32'(bus.reg_wr_addr_o), 32'(e_rd));
    chk({pfx, ".wr_en"},       32'(bus.reg_wr_en_o),   32'(e_we));
    chk({pfx, ".nf_reg2_data"}, bus_nf.reg2_rd_data_o, e_r2_nf);
  endtask

  // One clock: check combinational outputs, predict the register, check it
  task automatic cyc(input string tag);
    dec_t d;
    logic st;
    #1;
    d  = ref_dec(ins);
    st = ins_valid && ex_wr_en && ex_is_load && (ex_wr_addr != 0)
         && ((d.u1 && d.rs1 == ex_wr_addr) || (d.u2 && d.rs2 == ex_wr_addr));
    chk({tag, ".rd_addr1"}, 32'(rd_addr1), 32'(d.rs1));
    chk({tag, ".rd_addr2"}, 32'(rd_addr2), 32'(d.rs2));
    chk({tag, ".stall"},    32'(stall),    32'(st));
    chk({tag, ".nf_stall"}, 32'(nf_stall), 32'(st));
    if (flush) exp_bubble();
    else if (hold) ;
    else if (st || !ins_valid) exp_bubble();
    else begin
      e_ins = ins; e_addr = ins_addr; e_vld = 1;
      e_r1 = ref_opnd(d.rs1, rf1, 1'b1);
      e_r2 = ref_opnd(d.rs2, rf2, 1'b1);
      e_r2_nf = ref_opnd(d.rs2, rf2, 1'b0);
      e_imm = d.imm; e_rd = d.rd; e_we = d.we;
    end
    @(posedge clk);
    #1;
    check_regs(tag);
  endtask

  task automatic idle_side();
    ex_wr_en = 0; ex_wr_addr = 0; ex_wr_data = 0; ex_is_load = 0;
    mem_wr_en = 0; mem_wr_addr = 0; mem_wr_data = 0;
    hold = 0; flush = 0;
  endtask

  logic [6:0] opc_tbl [0:10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63,
                                  7'h37, 7'h17, 7'h6F, 7'h73, 7'h0F};

  initial begin
    logic [31:0] r;
    rst_n = 0; ins_valid = 0; ins = 32'h13; ins_addr = 0; rf1 = 0; rf2 = 0;
    idle_side();

    // reset state
    @(posedge clk); #1;
    exp_bubble();
    check_regs("reset");
    @(negedge clk); rst_n = 1;

    // immediate decode: addi x1,x0,-1
    ins_valid = 1; ins = 32'hFFF0_0093; ins_addr = 32'h100; rf1 = 32'h1234; rf2 = 32'h5678;
    cyc("addi");
    chk("addi.imm_const", bus.imm_o, 32'hFFFF_FFFF);
    chk("addi.rd_const", 32'(bus.reg_wr_addr_o), 32'd1);
    chk("addi.we_const", 32'(bus.reg_wr_en_o), 32'd1);

    // hold for 3 cycles with changing input -> unchanged
    hold = 1;
    for (int k = 0; k < 3; k++) begin
      ins = $urandom(); ins_addr = $urandom();
      cyc("hold");
    end
    chk("hold.imm_const", bus.imm_o, 32'hFFFF_FFFF);
    chk("hold.addr_const", bus.ins_addr_o, 32'h100);

    // hold together with flush -> bubble
    flush = 1; ins = 32'hFFF0_0093;
    cyc("holdflush");
    chk("holdflush.valid", 32'(bus.valid_o), 32'd0);
    hold = 0; flush = 0;

    // B-type immediate (bits 12 and 11 both come out set here)
    ins = 32'hFE00_0EE3; ins_addr = 32'h104;
    cyc("btype");
    chk("btype.imm_const", bus.imm_o, 32'hFFFF_FFFC);

    // forward priority on rs1=5: addi x6,x5,0
    ins = 32'h0002_8313; rf1 = 32'hCC;
    ex_wr_en = 1; ex_wr_addr = 5; ex_wr_data = 32'hAA; ex_is_load = 0;
    mem_wr_en = 1; mem_wr_addr = 5; mem_wr_data = 32'hBB;
    cyc("fwd_ex");
    chk("fwd_ex.const", bus.reg1_rd_data_o, 32'hAA);
    ex_wr_en = 0;
    cyc("fwd_mem");
    chk("fwd_mem.const", bus.reg1_rd_data_o, 32'hBB);
    ins = 32'h0000_0313; ex_wr_en = 1; ex_wr_addr = 0; mem_wr_addr = 0;
    cyc("fwd_x0");
    chk("fwd_x0.const", bus.reg1_rd_data_o, 32'h0);
    idle_side();

    // load-use: EX loads x3, ID is add x4,x3,x2
    ins = 32'h0021_8233; rf1 = 32'h11; rf2 = 32'h22;
    ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 3; ex_wr_data = 32'hDEAD;
    #1 chk("loaduse.stall_const", 32'(stall), 32'd1);
    cyc("loaduse");
    chk("loaduse.bubble", 32'(bus.valid_o), 32'd0);
    idle_side();
    mem_wr_en = 1; mem_wr_addr = 3; mem_wr_data = 32'h55;
    cyc("loaduse_retry");
    chk("retry.valid", 32'(bus.valid_o), 32'd1);
    chk("retry.data", bus.reg1_rd_data_o, 32'h55);
    idle_side();

    // FWD_EN=0 instance: EX/MEM match on rs2 must be ignored
    ins = 32'h0021_8233; rf2 = 32'h77;
    ex_wr_en = 1; ex_wr_addr = 2; ex_wr_data = 32'h99;
    mem_wr_en = 1; mem_wr_addr = 2; mem_wr_data = 32'h88;
    cyc("nofwd");
    chk("nofwd.const", bus_nf.reg2_rd_data_o, 32'h77);
    idle_side();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      r = $urandom();
      ins = {r[31:25], 2'b0, r[22:20], 2'b0, r[17:15], r[14:12], 2'b0, r[9:7],
             opc_tbl[$urandom_range(0, 10)]};
      ins_addr   = $urandom();
      ins_valid  = ($urandom_range(0, 9) != 0);
      hold       = ($urandom_range(0, 9) == 0);
      flush      = ($urandom_range(0, 11) == 0);
      rf1 = $urandom(); rf2 = $urandom();
      ex_wr_en   = $urandom_range(0, 1) != 0;
      ex_wr_addr = 5'($urandom_range(0, 7));
      ex_wr_data = $urandom();
      ex_is_load = ($urandom_range(0, 2) == 0);
      mem_wr_en  = $urandom_range(0, 1) != 0;
      mem_wr_addr = 5'($urandom_range(0, 7));
      mem_wr_data = $urandom();
      cyc("rand");
    end

    // asynchronous reset in mid-cycle with a valid instruction loaded
    idle_side(); ins_valid = 1; ins = 32'h0012_8093; rf1 = 32'h3; ins_addr = 32'h200;
    cyc("pre_rst");
    #2 rst_n = 0;
    #1;
    exp_bubble();
    check_regs("async_rst");
    @(negedge clk); rst_n = 1;
    cyc("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // overall time bound
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
